// File: rtl/pio_pkg.sv
// Shared definitions for the parallel I/O bank: register indices and bus width.
package pio_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [2:0] {
    PIO_OUT  = 3'd0,
    PIO_DIR  = 3'd1,
    PIO_IN   = 3'd2,
    PIO_PEND = 3'd3,
    PIO_IE   = 3'd4
  } pio_reg_e;

endpackage

// File: rtl/pio_filter.sv
// Single-bit input conditioning: 2-flop synchroniser, optionally followed by
// a debounce filter (enabled with macro PIO_DEBOUNCE_EN).
module pio_filter #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic in_f
);

  logic s1;
  logic s2;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic [CW-1:0] cnt;

  // Accept a new level only after DEB_CYC consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      in_f <= 1'b0;
    end else if (s2 == in_f) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYC - 1)) begin
      in_f <= s2;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign in_f = s2;
`endif

endmodule

// File: rtl/pio_bank.sv
// Parametrised GPIO bank: OUT/DIR/IN/PEND/IE registers on the peripheral bus,
// synchronised inputs and masked rising-edge interrupt.
// Optional input debounce is built when PIO_DEBOUNCE_EN is defined.
module pio_bank
  import pio_pkg::*;
#(
  parameter int unsigned    WIDTH   = 8,
  parameter int unsigned    DEB_CYC = 4,
  parameter logic [WIDTH-1:0] OUT_RST = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bus_en,
  input  logic             bus_wr,
  input  logic [2:0]       bus_addr,
  input  logic [BUS_W-1:0] bus_wdata,
  output logic [BUS_W-1:0] bus_rdata,
  output logic             bus_ack,
  input  logic [WIDTH-1:0] pio_i,
  output logic [WIDTH-1:0] pio_o,
  output logic [WIDTH-1:0] pio_oe,
  output logic             irq
);

  logic [WIDTH-1:0] out_r;
  logic [WIDTH-1:0] dir_r;
  logic [WIDTH-1:0] pend_r;
  logic [WIDTH-1:0] ie_r;
  logic [WIDTH-1:0] in_f;
  logic [WIDTH-1:0] in_f_d;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [BUS_W-1:0] rd_val;
  logic             wr_acc;
  logic             rd_acc;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH carry no meaning.
  assign unused_wdata = ^bus_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_filter #(.DEB_CYC(DEB_CYC)) u_filter (
      .clk  (clk),
      .reset(reset),
      .pin  (pio_i[i]),
      .in_f (in_f[i])
    );
  end

  assign wd     = bus_wdata[WIDTH-1:0];
  assign wr_acc = bus_en & bus_wr;
  assign rd_acc = bus_en & ~bus_wr;
  assign rise   = in_f & ~in_f_d;
  assign clr    = (wr_acc && bus_addr == PIO_PEND) ? wd : '0;

  assign pio_o  = out_r;
  assign pio_oe = dir_r;

  // Read multiplexer; unmapped indices and bits above WIDTH read zero.
  always_comb begin
    rd_val = '0;
    case (bus_addr)
      PIO_OUT:  rd_val[WIDTH-1:0] = out_r;
      PIO_DIR:  rd_val[WIDTH-1:0] = dir_r;
      PIO_IN:   rd_val[WIDTH-1:0] = in_f;
      PIO_PEND: rd_val[WIDTH-1:0] = pend_r;
      PIO_IE:   rd_val[WIDTH-1:0] = ie_r;
      default:  rd_val = '0;
    endcase
  end

  // Bus registers, edge capture (set beats W1C) and registered irq.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_r     <= OUT_RST;
      dir_r     <= '0;
      pend_r    <= '0;
      ie_r      <= '0;
      in_f_d    <= '0;
      bus_rdata <= '0;
      bus_ack   <= 1'b0;
      irq       <= 1'b0;
    end else begin
      bus_ack <= bus_en;
      in_f_d  <= in_f;
      pend_r  <= (pend_r & ~clr) | rise;
      irq     <= |(pend_r & ie_r);
      if (rd_acc) begin
        bus_rdata <= rd_val;
      end
      if (wr_acc) begin
        case (bus_addr)
          PIO_OUT: out_r <= wd;
          PIO_DIR: dir_r <= wd;
          PIO_IE:  ie_r  <= wd;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pio_bank.sv
// Self-checking bench for pio_bank: an 8-bit instance with OUT_RST=8'hA5 and
// a 32-bit instance sharing the same bus stimulus.
module tb_pio_bank;

  localparam logic [2:0] A_OUT  = 3'd0;
  localparam logic [2:0] A_DIR  = 3'd1;
  localparam logic [2:0] A_IN   = 3'd2;
  localparam logic [2:0] A_PEND = 3'd3;
  localparam logic [2:0] A_IE   = 3'd4;

`ifdef PIO_DEBOUNCE_EN
  localparam int FILT = 4;
`else
  localparam int FILT = 0;
`endif
  // Cycles from a pin rise to PEND set, and to irq high.
  localparam int PEND_LAT = 3 + FILT;
  localparam int IRQ_LAT  = PEND_LAT + 1;
  localparam int HOLD     = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_en;
  logic        bus_wr;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [7:0]  pio_i;
  logic [31:0] pio32_i;

  logic [31:0] rdata8, rdata32;
  logic        ack8, ack32;
  logic [7:0]  pio_o8, pio_oe8;
  logic [31:0] pio_o32, pio_oe32;
  logic        irq8, irq32;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference state, maintained from the register-map rules.
  logic [7:0] m_out, m_dir, m_ie, m_pend;

  always #5 clk = ~clk;

  pio_bank #(.WIDTH(8), .DEB_CYC(4), .OUT_RST(8'hA5)) u_w8 (
    .clk(clk), .reset(reset), .bus_en(bus_en), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata8),
    .bus_ack(ack8), .pio_i(pio_i), .pio_o(pio_o8), .pio_oe(pio_oe8),
    .irq(irq8)
  );

  pio_bank #(.WIDTH(32), .DEB_CYC(4), .OUT_RST(32'h0)) u_w32 (
    .clk(clk), .reset(reset), .bus_en(bus_en), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(rdata32),
    .bus_ack(ack32), .pio_i(pio32_i), .pio_o(pio_o32), .pio_oe(pio_oe32),
    .irq(irq32)
  );

  task automatic bus_xfer(input logic wr, input logic [2:0] a, input logic [31:0] d,
                          output logic [31:0] r8, output logic [31:0] r32, output logic ak);
    @(negedge clk);
    bus_en = 1'b1; bus_wr = wr; bus_addr = a; bus_wdata = d;
    @(negedge clk);
    bus_en = 1'b0; bus_wr = 1'b0;
    r8 = rdata8; r32 = rdata32; ak = ack8;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus_en = 1'b0; bus_wr = 1'b0; bus_addr = '0; bus_wdata = '0;
    pio_i = '0; pio32_i = '0;
    #22;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    bus_en = 1'b1; bus_wr = 1'b1; bus_addr = A_OUT; bus_wdata = 32'h55;
    @(posedge clk); #2;
    n_total++; if (ack8 !== 1'b1) $display("FAIL pre_reset_ack got=%b exp=1", ack8); else n_pass++;
    reset = 1'b1; bus_en = 1'b0;
    #1;
    n_total++; if (pio_o8 !== 8'hA5) $display("FAIL reset_pio_o got=%h exp=a5", pio_o8); else n_pass++;
    n_total++; if (pio_oe8 !== 8'h00) $display("FAIL reset_pio_oe got=%h exp=00", pio_oe8); else n_pass++;
    n_total++; if (irq8 !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq8); else n_pass++;
    n_total++; if (ack8 !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack8); else n_pass++;
    n_total++; if (rdata8 !== 32'h0) $display("FAIL reset_rdata got=%h exp=0", rdata8); else n_pass++;
    @(negedge clk); reset = 1'b0;
    m_out = 8'hA5; m_dir = '0; m_ie = '0; m_pend = '0;
  endtask

  task automatic test_write_read();
    logic [31:0] r8, r32; logic ak;
    bus_xfer(1'b1, A_DIR, 32'h0F, r8, r32, ak); m_dir = 8'h0F;
    n_total++; if (ak !== 1'b1) $display("FAIL wr_dir_ack got=%b exp=1", ak); else n_pass++;
    n_total++; if (pio_oe8 !== m_dir) $display("FAIL wr_dir_pin got=%h exp=%h", pio_oe8, m_dir); else n_pass++;
    bus_xfer(1'b1, A_OUT, 32'h3C, r8, r32, ak); m_out = 8'h3C;
    n_total++; if (pio_o8 !== m_out) $display("FAIL wr_out_pin got=%h exp=%h", pio_o8, m_out); else n_pass++;
    @(negedge clk);
    n_total++; if (ack8 !== 1'b0) $display("FAIL ack_one_cycle got=%b exp=0", ack8); else n_pass++;
    bus_xfer(1'b0, A_DIR, 32'h0, r8, r32, ak);
    n_total++; if (ak !== 1'b1) $display("FAIL rd_dir_ack got=%b exp=1", ak); else n_pass++;
    n_total++; if (r8 !== {24'h0, m_dir}) $display("FAIL rd_dir got=%h exp=%h", r8, {24'h0, m_dir}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); bus_en = 1'b1; bus_wr = 1'b0; bus_addr = A_OUT;
    @(negedge clk);
    n_total++; if (ack8 !== 1'b1 || rdata8 !== {24'h0, m_out})
      $display("FAIL b2b_first got ack=%b data=%h exp ack=1 data=%h", ack8, rdata8, {24'h0, m_out}); else n_pass++;
    bus_addr = A_DIR;
    @(negedge clk);
    n_total++; if (ack8 !== 1'b1 || rdata8 !== {24'h0, m_dir})
      $display("FAIL b2b_second got ack=%b data=%h exp ack=1 data=%h", ack8, rdata8, {24'h0, m_dir}); else n_pass++;
    bus_en = 1'b0;
    @(negedge clk);
    n_total++; if (ack8 !== 1'b0 || rdata8 !== {24'h0, m_dir})
      $display("FAIL b2b_idle got ack=%b data=%h exp ack=0 data=%h", ack8, rdata8, {24'h0, m_dir}); else n_pass++;
  endtask

  task automatic test_edge_irq();
    logic [31:0] r8, r32; logic ak; int first;
    bus_xfer(1'b1, A_IE, 32'h01, r8, r32, ak); m_ie = 8'h01;
    @(negedge clk); pio_i[0] = 1'b1; m_pend[0] = 1'b1;
    first = 0;
    for (int k = 1; k <= IRQ_LAT + 4; k++) begin
      @(negedge clk);
      if (irq8 === 1'b1 && first == 0) first = k;
    end
    n_total++; if (first != IRQ_LAT) $display("FAIL irq_latency got=%0d exp=%0d", first, IRQ_LAT); else n_pass++;
    bus_xfer(1'b0, A_PEND, 32'h0, r8, r32, ak);
    n_total++; if (r8 !== {24'h0, m_pend}) $display("FAIL pend_set got=%h exp=%h", r8, {24'h0, m_pend}); else n_pass++;
    bus_xfer(1'b1, A_PEND, 32'h01, r8, r32, ak); m_pend[0] = 1'b0;
    @(negedge clk);
    n_total++; if (irq8 !== 1'b0) $display("FAIL irq_clear got=%b exp=0", irq8); else n_pass++;
    bus_xfer(1'b0, A_PEND, 32'h0, r8, r32, ak);
    n_total++; if (r8 !== {24'h0, m_pend}) $display("FAIL pend_w1c got=%h exp=%h", r8, {24'h0, m_pend}); else n_pass++;
  endtask

  task automatic test_set_wins();
    logic [31:0] r8, r32; logic ak;
    @(negedge clk); pio_i[2] = 1'b1;
    repeat (PEND_LAT - 2) @(negedge clk);
    bus_xfer(1'b1, A_PEND, 32'h04, r8, r32, ak);
    m_pend[2] = 1'b1;
    bus_xfer(1'b0, A_PEND, 32'h0, r8, r32, ak);
    n_total++; if (r8 !== {24'h0, m_pend}) $display("FAIL set_wins got=%h exp=%h", r8, {24'h0, m_pend}); else n_pass++;
    bus_xfer(1'b1, A_PEND, 32'h04, r8, r32, ak); m_pend[2] = 1'b0;
    bus_xfer(1'b0, A_PEND, 32'h0, r8, r32, ak);
    n_total++; if (r8 !== {24'h0, m_pend}) $display("FAIL set_wins_clear got=%h exp=%h", r8, {24'h0, m_pend}); else n_pass++;
  endtask

`ifdef PIO_DEBOUNCE_EN
  task automatic test_debounce();
    logic [31:0] r8, r32; logic ak;
    @(negedge clk); pio_i[1] = 1'b1;
    repeat (3) @(negedge clk); pio_i[1] = 1'b0;
    repeat (HOLD) @(negedge clk);
    bus_xfer(1'b0, A_IN, 32'h0, r8, r32, ak);
    n_total++; if (r8[1] !== 1'b0) $display("FAIL deb_short_in got=%b exp=0", r8[1]); else n_pass++;
    bus_xfer(1'b0, A_PEND, 32'h0, r8, r32, ak);
    n_total++; if (r8[1] !== 1'b0) $display("FAIL deb_short_pend got=%b exp=0", r8[1]); else n_pass++;
    @(negedge clk); pio_i[1] = 1'b1;
    fork
      begin repeat (6) @(negedge clk); pio_i[1] = 1'b0; end
    join_none
    repeat (5) @(negedge clk);
    bus_xfer(1'b0, A_IN, 32'h0, r8, r32, ak);
    n_total++; if (r8[1] !== 1'b1) $display("FAIL deb_long_in got=%b exp=1", r8[1]); else n_pass++;
    repeat (HOLD) @(negedge clk);
    bus_xfer(1'b0, A_PEND, 32'h0, r8, r32, ak);
    n_total++; if (r8[1] !== 1'b1) $display("FAIL deb_long_pend got=%b exp=1", r8[1]); else n_pass++;
    bus_xfer(1'b1, A_PEND, 32'h02, r8, r32, ak);
  endtask
`endif

  task automatic test_unmapped();
    logic [31:0] r8, r32; logic ak;
    bus_xfer(1'b0, A_OUT, 32'h0, r8, r32, ak);
    bus_xfer(1'b0, 3'd6, 32'h0, r8, r32, ak);
    n_total++; if (ak !== 1'b1 || r8 !== 32'h0) $display("FAIL rd_unmapped got ack=%b data=%h exp ack=1 data=0", ak, r8); else n_pass++;
    bus_xfer(1'b1, A_IN, 32'hFF, r8, r32, ak);
    n_total++; if (ak !== 1'b1) $display("FAIL wr_in_ack got=%b exp=1", ak); else n_pass++;
    bus_xfer(1'b1, 3'd5, 32'hFF, r8, r32, ak);
    bus_xfer(1'b0, A_IN, 32'h0, r8, r32, ak);
    n_total++; if (r8 !== {24'h0, pio_i}) $display("FAIL in_unchanged got=%h exp=%h", r8, {24'h0, pio_i}); else n_pass++;
    bus_xfer(1'b0, A_OUT, 32'h0, r8, r32, ak);
    n_total++; if (r8 !== {24'h0, m_out}) $display("FAIL out_after_unmapped got=%h exp=%h", r8, {24'h0, m_out}); else n_pass++;
  endtask

  task automatic test_width32();
    logic [31:0] r8, r32; logic ak;
    bus_xfer(1'b1, A_OUT, 32'hDEADBEEF, r8, r32, ak); m_out = 8'hEF;
    n_total++; if (pio_o32 !== 32'hDEADBEEF) $display("FAIL w32_pin got=%h exp=deadbeef", pio_o32); else n_pass++;
    bus_xfer(1'b0, A_OUT, 32'h0, r8, r32, ak);
    n_total++; if (r32 !== 32'hDEADBEEF) $display("FAIL w32_read got=%h exp=deadbeef", r32); else n_pass++;
    n_total++; if (r8 !== 32'h000000EF) $display("FAIL w8_zero_ext got=%h exp=000000ef", r8); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] r8, r32; logic ak;
    logic [7:0] prev, nv, v, exp_pend;
    bus_xfer(1'b1, A_PEND, 32'hFF, r8, r32, ak); m_pend = '0;
    prev = pio_i;
    for (int it = 0; it < 20; it++) begin
      nv = 8'($urandom);
      @(negedge clk); pio_i = nv;
      repeat (HOLD) @(negedge clk);
      m_pend = m_pend | (nv & ~prev);
      prev = nv;
      bus_xfer(1'b0, A_IN, 32'h0, r8, r32, ak);
      n_total++; if (r8 !== {24'h0, nv}) $display("FAIL rnd_in it=%0d got=%h exp=%h", it, r8, nv); else n_pass++;
      bus_xfer(1'b0, A_PEND, 32'h0, r8, r32, ak);
      exp_pend = m_pend;
      n_total++; if (r8 !== {24'h0, exp_pend}) $display("FAIL rnd_pend it=%0d got=%h exp=%h", it, r8, exp_pend); else n_pass++;
      m_ie = 8'($urandom);
      bus_xfer(1'b1, A_IE, {24'h0, m_ie}, r8, r32, ak);
      repeat (2) @(negedge clk);
      n_total++; if (irq8 !== |(m_pend & m_ie)) $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, irq8, |(m_pend & m_ie)); else n_pass++;
      v = 8'($urandom);
      bus_xfer(1'b1, A_PEND, {24'h0, v}, r8, r32, ak); m_pend = m_pend & ~v;
      m_out = 8'($urandom);
      bus_xfer(1'b1, A_OUT, {24'h0, m_out}, r8, r32, ak);
      n_total++; if (pio_o8 !== m_out) $display("FAIL rnd_out it=%0d got=%h exp=%h", it, pio_o8, m_out); else n_pass++;
      m_dir = 8'($urandom);
      bus_xfer(1'b1, A_DIR, {24'h0, m_dir}, r8, r32, ak);
      n_total++; if (pio_oe8 !== m_dir) $display("FAIL rnd_dir it=%0d got=%h exp=%h", it, pio_oe8, m_dir); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_edge_irq();
    test_set_wins();
`ifdef PIO_DEBOUNCE_EN
    test_debounce();
`endif
    test_unmapped();
    test_width32();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
